// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operation request handshake plus result,
// HI/LO and status outputs.
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] read_data_1;
    logic [WIDTH-1:0] alu_src_output;
    logic             out_valid;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output in_valid, alu_ctrl, shamt, read_data_1, alu_src_output,
        input  in_ready, out_valid, alu_result, zero, hi, lo, busy
    );

    modport slave (
        input  in_valid, alu_ctrl, shamt, read_data_1, alu_src_output,
        output in_ready, out_valid, alu_result, zero, hi, lo, busy
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide writing the HI/LO pair.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic    clk,
    input  logic    reset,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR   = 4'b0011,
        OP_SLL  = 4'b0100, OP_SLTU = 4'b0101, OP_SUB  = 4'b0110, OP_SLT   = 4'b0111,
        OP_SRL  = 4'b1000, OP_SRA  = 4'b1001, OP_LUI  = 4'b1010, OP_MULT  = 4'b1011,
        OP_NOR  = 4'b1100, OP_MULTU = 4'b1101, OP_DIV = 4'b1110, OP_DIVU  = 4'b1111
    } op_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               neg_q, neg_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

    op_t                op;
    logic [WIDTH-1:0]   op_a, op_b, mag_a, mag_b, alu_out;
    logic               is_signed, a_neg, b_neg;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, mul_prod;
    logic [WIDTH-1:0]   div_quo, div_rem;

    assign op   = op_t'(bus.alu_ctrl);
    assign op_a = bus.read_data_1;
    assign op_b = bus.alu_src_output;

    always_comb begin
        alu_out = '0;
        case (op)
            OP_AND:  alu_out = op_a & op_b;
            OP_OR:   alu_out = op_a | op_b;
            OP_ADD:  alu_out = op_a + op_b;
            OP_XOR:  alu_out = op_a ^ op_b;
            OP_SLL:  alu_out = op_b << bus.shamt;
            OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            OP_SUB:  alu_out = op_a - op_b;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SRL:  alu_out = op_b >> bus.shamt;
            OP_SRA:  alu_out = $unsigned($signed(op_b) >>> bus.shamt);
            OP_LUI:  alu_out = op_b << (WIDTH/2);
            OP_NOR:  alu_out = ~(op_a | op_b);
            default: alu_out = '0;
        endcase
    end

    // Iterative datapath works on magnitudes; signs are re-applied on the last step.
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = is_signed && op_a[WIDTH-1];
        b_neg     = is_signed && op_b[WIDTH-1];
        mag_a     = a_neg ? -op_a : op_a;
        mag_b     = b_neg ? -op_b : op_b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        mul_prod  = neg_q ? -mul_next : mul_next;

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = !div_diff[WIDTH] ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                     : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        div_quo   = div0_q ? '1 : (neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0]);
        div_rem   = neg_rem_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        neg_rem_d   = neg_rem_q;
        div0_d      = div0_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        opnd_d  = mag_a;
                        neg_d   = a_neg ^ b_neg;
                        cnt_d   = SHW'(WIDTH-1);
                        state_d = MUL;
                    end
                    OP_DIV, OP_DIVU: begin
                        acc_d     = {{WIDTH{1'b0}}, mag_a};
                        opnd_d    = mag_b;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        div0_d    = (op_b == '0);
                        cnt_d     = SHW'(WIDTH-1);
                        state_d   = DIV;
                    end
                    default: begin
                        result_d    = alu_out;
                        zero_d      = (alu_out == '0);
                        out_valid_d = 1'b1;
                    end
                endcase
            end
            // The final iteration loads HI/LO directly so out_valid coincides with DONE.
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    hi_d        = mul_prod[2*WIDTH-1:WIDTH];
                    lo_d        = mul_prod[WIDTH-1:0];
                    result_d    = mul_prod[WIDTH-1:0];
                    zero_d      = (mul_prod[WIDTH-1:0] == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    hi_d        = div_rem;
                    lo_d        = div_quo;
                    result_d    = div_quo;
                    zero_d      = (div_quo == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            neg_rem_q   <= neg_rem_d;
            div0_q      <= div0_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q == MUL) || (state_q == DIV);
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = result_q;
    assign bus.zero       = zero_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): directed requests push expected
// responses; a negedge monitor pops and compares on every out_valid.
module tb_seq_alu;
    logic clk = 1'b0;
    logic reset = 1'b1;

    seq_alu_if #(.WIDTH(32), .SHW(5)) bus ();
    seq_alu #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk({e.name, ".cycle"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, ".result"}, bus.alu_result, e.res);
                chk({e.name, ".zero"}, 32'(bus.zero), 32'(e.res == 32'd0));
                chk({e.name, ".hi"}, bus.hi, e.hi);
                chk({e.name, ".lo"}, bus.lo, e.lo);
            end
        end
    end

    task automatic issue(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] sh, logic [31:0] er, logic multi,
                         logic [31:0] ehi, logic [31:0] elo);
        int unsigned w = 0;
        exp_t e;
        bus.alu_ctrl       = op;
        bus.read_data_1    = a;
        bus.alu_src_output = b;
        bus.shamt          = sh;
        bus.in_valid       = 1'b1;
        while (bus.in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            chk({name, ".in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        if (multi) begin
            m_hi = ehi;
            m_lo = elo;
        end
        e.name = name;
        e.res  = er;
        e.hi   = m_hi;
        e.lo   = m_lo;
        e.cyc  = cyc + 1 + (multi ? 32 : 0);
        q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned bad;
        int unsigned w;
        bus.in_valid       = 1'b0;
        bus.alu_ctrl       = '0;
        bus.shamt          = '0;
        bus.read_data_1    = '0;
        bus.alu_src_output = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.result", bus.alu_result, 32'd0);
        chk("rst.zero", 32'(bus.zero), 32'd1);
        chk("rst.hi", bus.hi, 32'd0);
        chk("rst.lo", bus.lo, 32'd0);

        // back-to-back single-cycle ops
        issue("add",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, '0, '0);
        issue("sub",  4'b0110, 32'd5,        32'd5,        5'd0,  32'h00000000, 1'b0, '0, '0);
        issue("sra",  4'b1001, 32'd0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0, '0, '0);
        issue("slt",  4'b0111, 32'hFFFFFFFF, 32'd1,        5'd0,  32'h00000001, 1'b0, '0, '0);
        issue("sltu", 4'b0101, 32'hFFFFFFFF, 32'd1,        5'd0,  32'h00000000, 1'b0, '0, '0);
        issue("lui",  4'b1010, 32'd0,        32'h00001234, 5'd0,  32'h12340000, 1'b0, '0, '0);
        issue("sll",  4'b0100, 32'd0,        32'h00000001, 5'd31, 32'h80000000, 1'b0, '0, '0);
        issue("srl",  4'b1000, 32'd0,        32'h80000000, 5'd31, 32'h00000001, 1'b0, '0, '0);
        issue("nor",  4'b1100, 32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0, '0, '0);
        issue("or",   4'b0001, 32'h000000F0, 32'h0000000F, 5'd0,  32'h000000FF, 1'b0, '0, '0);
        issue("xor",  4'b0011, 32'hDEADBEEF, 32'hDEADBEEF, 5'd0,  32'h00000000, 1'b0, '0, '0);

        issue("mult", 4'b1011, 32'hFFFFFFFD, 32'd7, 5'd0, 32'hFFFFFFEB, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
        bad = 0;
        repeat (32) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
            @(negedge clk);
        end
        if (bus.in_ready !== 1'b0) bad++;
        chk("mult.in_ready_low", 32'(bad), 32'd0);

        issue("and",    4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 32'h0F000F00, 1'b0, '0, '0);
        issue("div",    4'b1110, 32'hFFFFFFF9, 32'd2, 5'd0, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue("divu0",  4'b1111, 32'd7, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'h00000007, 32'hFFFFFFFF);
        issue("multu",  4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 1'b1, 32'hFFFFFFFE, 32'h00000001);
        issue("divmin", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b1, 32'h00000000, 32'h80000000);
        issue("div0",   4'b1110, 32'hFFFFFFF9, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF);
        issue("add2",   4'b0010, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, '0, '0);

        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain.pending", 32'(q.size()), 32'd0);

        // abort an in-flight DIVU with reset; a request during reset must be ignored
        bus.alu_ctrl       = 4'b1111;
        bus.read_data_1    = 32'd100;
        bus.alu_src_output = 32'd3;
        bus.in_valid       = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort.busy_before", 32'(bus.busy), 32'd1);
        reset              = 1'b1;
        bus.alu_ctrl       = 4'b0010;
        bus.read_data_1    = 32'd1;
        bus.alu_src_output = 32'd1;
        bus.in_valid       = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        m_hi         = '0;
        m_lo         = '0;
        chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort.hi", bus.hi, 32'd0);
        chk("abort.lo", bus.lo, 32'd0);
        chk("abort.result", bus.alu_result, 32'd0);
        chk("abort.zero", 32'(bus.zero), 32'd1);
        repeat (40) @(negedge clk);
        chk("abort.busy_after", 32'(bus.busy), 32'd0);
        chk("abort.in_ready_after", 32'(bus.in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits, even, legal range 8..64.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width, equal to clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port alu_ctrl  input  4  operation code.
REQ-008 SHALL have port shamt  input  SHW  shift amount for SLL/SRL/SRA.
REQ-009 SHALL have port read_data_1  input  WIDTH  operand A.
REQ-010 SHALL have port alu_src_output  input  WIDTH  operand B.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse: result, zero, hi and lo are valid.
REQ-012 SHALL have port alu_result  output  WIDTH  registered result.
REQ-013 SHALL have port zero  output  1  registered; 1 iff alu_result==0.
REQ-014 SHALL have port hi  output  WIDTH  HI register: product upper half or remainder.
REQ-015 SHALL have port lo  output  WIDTH  LO register: product lower half or quotient.
REQ-016 SHALL have port busy  output  1  multi-cycle operation in progress.

Function
REQ-017 SHALL accept a request when in_valid && in_ready; SHALL sample operands, alu_ctrl and shamt only at acceptance.
REQ-018 SHALL decode alu_ctrl as: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SLTU, 0110 SUB, 0111 SLT, 1000 SRL, 1001 SRA, 1010 LUI, 1011 MULT, 1100 NOR, 1101 MULTU, 1110 DIV, 1111 DIVU.
REQ-019 SHALL compute single-cycle ops (all except MULT/MULTU/DIV/DIVU) on the accept edge and assert out_valid in the next cycle for exactly one cycle.
REQ-020 SHALL wrap ADD/SUB modulo 2^WIDTH with no overflow trap; SLT is signed, SLTU is unsigned, both produce result 0 or 1.
REQ-021 SHALL apply SLL/SRL/SRA to operand B by shamt; SRA SHALL sign-fill; LUI SHALL produce B << (WIDTH/2).
REQ-022 SHALL use state machine IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE; busy=1 in MUL and DIV.
REQ-023 SHALL, in IDLE, keep the state IDLE after a single-cycle op, so back-to-back requests are accepted every cycle.
REQ-024 SHALL, in IDLE, move to MUL on accepting MULT/MULTU and to DIV on accepting DIV/DIVU.
REQ-025 SHALL implement MUL as an iterative shift-add over unsigned magnitudes: one bit per cycle, WIDTH cycles; then go to DONE.
REQ-026 SHALL implement DIV as restoring division over unsigned magnitudes: one bit per cycle, WIDTH cycles; then go to DONE.
REQ-027 SHALL, for signed ops, negate the product when operand signs differ; negate the quotient when signs differ; give the remainder the sign of the dividend.
REQ-028 SHALL, in DONE, load hi/lo, set alu_result=lo, assert out_valid for one cycle, and return to IDLE, so out_valid comes WIDTH+1 cycles after acceptance.
REQ-029 SHALL leave hi/lo unchanged after single-cycle ops.
REQ-030 SHALL handle divide by zero without stalling: lo=all ones, hi=dividend (DIV and DIVU).
REQ-031 SHALL handle signed DIV of the most-negative value by -1 as: lo=most-negative value, hi=0.
REQ-032 SHALL ignore in_valid while busy or in DONE; the requester must hold the request until in_ready.
REQ-033 SHALL hold alu_result and zero between out_valid pulses.

Reset
REQ-034 SHALL, on reset, clear state to IDLE, out_valid, busy, alu_result, hi and lo to 0, and set zero=1 and in_ready=1 on the following cycle.
REQ-035 SHALL let reset abort an in-flight MUL/DIV with no out_valid, and give reset priority over a same-cycle request.

Verification
REQ-036 SHALL verify, with WIDTH=32: ADD 0x7FFFFFFF+1 -> result 0x80000000, zero=0, out_valid next cycle; SUB 5-5 -> result 0, zero=1.
REQ-037 SHALL verify SRA B=0x80000000, shamt=4 -> 0xF8000000; SLT -1,1 -> 1; SLTU -1,1 -> 0; LUI B=0x1234 -> 0x12340000.
REQ-038 SHALL verify MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-039 SHALL verify DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-040 SHALL verify back-to-back single-cycle ops on consecutive cycles produce consecutive out_valid pulses with correct results.
REQ-041 SHALL verify reset asserted at cycle 10 of a DIVU -> no out_valid, in_ready=1 and hi=lo=0 after reset.
